// File: rtl/distance_pkg.sv
// Shared definitions for the distance filtering path.
// Holds the distance width, the filter FSM state encoding and the default
// range/threshold/timeout constants. The ranging stage and the motor control
// logic use the same constants, so all three blocks agree on the limits.
package distance_pkg;

  localparam int unsigned DIST_WIDTH    = 16;
  localparam int unsigned DIST_AVG_LOG2 = 2;
  localparam int unsigned DIST_MAX_MM   = 4000;
  localparam int unsigned DIST_NEAR_MM  = 300;
  localparam int unsigned DIST_FAR_MM   = 400;
  localparam int unsigned DIST_TIMEOUT  = 100000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    STALE = 2'd2
  } filt_state_e;

endpackage

// File: rtl/moving_avg_buf.sv
// Circular sample buffer with a running sum for a power-of-two moving average.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   load       : prefill every entry with din and set sum = din * depth
//   push       : replace the oldest entry with din and update sum incrementally
//   din        : sample to load or push
//   sum        : running sum of all entries (WIDTH+AVG_LOG2 bits, cannot overflow)
// AVG_LOG2 must be at least 1. load takes priority over push.
module moving_avg_buf
  import distance_pkg::*;
#(
  parameter int unsigned WIDTH    = DIST_WIDTH,
  parameter int unsigned AVG_LOG2 = DIST_AVG_LOG2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH+AVG_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = WIDTH + AVG_LOG2;

  logic [WIDTH-1:0]    entry_q [DEPTH];
  logic [WIDTH-1:0]    entry_d [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]    sum_q, sum_d;

  // Next-state for the buffer. The write pointer always addresses the oldest
  // entry, so a push subtracts exactly the value it is about to overwrite.
  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i] = din;
      end
      sum_d    = SUM_W'(din) << AVG_LOG2;
      wr_ptr_d = '0;
    end else if (push) begin
      entry_d[wr_ptr_q] = din;
      sum_d             = sum_q - SUM_W'(entry_q[wr_ptr_q]) + SUM_W'(din);
      wr_ptr_d          = wr_ptr_q + AVG_LOG2'(1);
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/distance_filter.sv
// Distance filter between the ultrasonic ranging stage and steering/motor control.
// Rejects out-of-range samples, smooths accepted samples with a moving average,
// derives a hysteretic obstacle flag and raises stale when the sensor goes quiet.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   distance     : raw measurement in mm, qualified by sample_valid
//   sample_valid : one-cycle strobe per new measurement
//   filtered_mm  : moving-average distance in mm
//   filt_valid   : one-cycle pulse when filtered_mm updates (two cycles after the sample)
//   obstacle     : near-object flag with hysteresis, high whenever data is untrusted
//   stale        : no accepted sample for TIMEOUT cycles
//   reject       : one-cycle pulse, the cycle after a discarded sample
module distance_filter
  import distance_pkg::*;
#(
  parameter int unsigned WIDTH    = DIST_WIDTH,
  parameter int unsigned AVG_LOG2 = DIST_AVG_LOG2,
  parameter int unsigned MAX_MM   = DIST_MAX_MM,
  parameter int unsigned NEAR_MM  = DIST_NEAR_MM,
  parameter int unsigned FAR_MM   = DIST_FAR_MM,
  parameter int unsigned TIMEOUT  = DIST_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] distance,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] filtered_mm,
  output logic             filt_valid,
  output logic             obstacle,
  output logic             stale,
  output logic             reject
);

  localparam int unsigned      SUM_W   = WIDTH + AVG_LOG2;
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_MM);
  localparam logic [WIDTH-1:0] NEAR_V  = WIDTH'(NEAR_MM);
  localparam logic [WIDTH-1:0] FAR_V   = WIDTH'(FAR_MM);

  filt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] filtered_q, filtered_d;
  logic             filt_valid_q, filt_valid_d;
  logic             obstacle_q, obstacle_d;
  logic             stale_q, stale_d;
  logic             reject_q, reject_d;

  logic             accept;
  logic             rejected;
  logic             load;
  logic             push;
  logic             timeout_hit;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] avg;

  assign accept      = sample_valid && (distance != '0) && (distance <= MAX_V);
  assign rejected    = sample_valid && !accept;
  // Coming out of EMPTY or STALE there is no trustworthy history, so the
  // window is prefilled with the first sample instead of averaging in old data.
  assign load        = accept && (state_q != TRACK);
  assign push        = accept && (state_q == TRACK);
  // An accepted sample in the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q == TRACK) && !accept && (cnt_q == CNT_MAX);
  assign avg         = WIDTH'(sum >> AVG_LOG2);

  moving_avg_buf #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .push  (push),
    .din   (distance),
    .sum   (sum)
  );

  // FSM next-state and stale flag.
  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    case (state_q)
      EMPTY, STALE: begin
        if (accept) begin
          state_d = TRACK;
          stale_d = 1'b0;
        end
      end
      TRACK: begin
        if (timeout_hit) begin
          state_d = STALE;
          stale_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        stale_d = 1'b1;
      end
    endcase
  end

  // Timeout counter, output pipeline and obstacle hysteresis. upd_q marks the
  // cycle after an accepted sample, when the buffer sum already includes it.
  always_comb begin
    cnt_d        = cnt_q;
    upd_d        = accept;
    filtered_d   = filtered_q;
    filt_valid_d = upd_q;
    obstacle_d   = obstacle_q;
    reject_d     = rejected;

    if (accept) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (upd_q) begin
      filtered_d = avg;
      if (avg < NEAR_V) begin
        obstacle_d = 1'b1;
      end else if (avg > FAR_V) begin
        obstacle_d = 1'b0;
      end
    end

    // Losing the sensor is treated as an obstacle so the vehicle stops.
    if (timeout_hit) begin
      obstacle_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= EMPTY;
      cnt_q        <= '0;
      upd_q        <= 1'b0;
      filtered_q   <= '0;
      filt_valid_q <= 1'b0;
      obstacle_q   <= 1'b1;
      stale_q      <= 1'b1;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      upd_q        <= upd_d;
      filtered_q   <= filtered_d;
      filt_valid_q <= filt_valid_d;
      obstacle_q   <= obstacle_d;
      stale_q      <= stale_d;
      reject_q     <= reject_d;
    end
  end

  assign filtered_mm = filtered_q;
  assign filt_valid  = filt_valid_q;
  assign obstacle    = obstacle_q;
  assign stale       = stale_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_distance_filter.sv
// Self-checking bench for distance_filter (TIMEOUT shortened to 16 cycles).
// A reference model keeps the averaging window as a queue of accepted samples
// and schedules each filtered result two cycles after its sample.
module tb_distance_filter;

  localparam int TB_TIMEOUT = 16;
  localparam int TB_MAX     = 4000;
  localparam int TB_NEAR    = 300;
  localparam int TB_FAR     = 400;
  localparam int TB_DEPTH   = 4;

  logic        clk;
  logic        reset;
  logic [15:0] distance;
  logic        sample_valid;
  logic [15:0] filtered_mm;
  logic        filt_valid;
  logic        obstacle;
  logic        stale;
  logic        reject;

  int checks;
  int errors;

  // Reference model state
  int          edge_n;
  int          idle;
  bit          m_track;
  int          window[$];
  int          due_q[$];
  int          val_q[$];
  logic        exp_fv;
  logic        exp_obstacle;
  logic        exp_stale;
  logic        exp_reject;
  logic [15:0] exp_filtered;

  distance_filter #(
    .WIDTH    (16),
    .AVG_LOG2 (2),
    .MAX_MM   (TB_MAX),
    .NEAR_MM  (TB_NEAR),
    .FAR_MM   (TB_FAR),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .distance     (distance),
    .sample_valid (sample_valid),
    .filtered_mm  (filtered_mm),
    .filt_valid   (filt_valid),
    .obstacle     (obstacle),
    .stale        (stale),
    .reject       (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] rand_dist();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'd0;
    if (r == 1) return 16'($urandom_range(TB_MAX + 1, 65535));
    if (r == 2) return 16'(TB_MAX);
    return 16'($urandom_range(1, TB_MAX));
  endfunction

  task automatic model_reset();
    window.delete();
    due_q.delete();
    val_q.delete();
    m_track      = 1'b0;
    idle         = 0;
    exp_fv       = 1'b0;
    exp_obstacle = 1'b1;
    exp_stale    = 1'b1;
    exp_reject   = 1'b0;
    exp_filtered = 16'd0;
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Drive one clock cycle of input and advance the model to the state the
  // outputs should show right after that clock edge.
  task automatic tick(input logic v, input logic [15:0] d);
    bit acc;
    int s;
    int val;
    acc          = v && (d != 16'd0) && (int'(d) <= TB_MAX);
    sample_valid = v;
    distance     = d;
    @(posedge clk);
    edge_n++;
    exp_reject = v && !acc;
    exp_fv     = 1'b0;
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      val          = val_q.pop_front();
      exp_fv       = 1'b1;
      exp_filtered = 16'(val);
      if (val < TB_NEAR) exp_obstacle = 1'b1;
      else if (val > TB_FAR) exp_obstacle = 1'b0;
    end
    if (acc) begin
      if (!m_track) begin
        window.delete();
        repeat (TB_DEPTH) window.push_back(int'(d));
        m_track   = 1'b1;
        exp_stale = 1'b0;
      end else begin
        void'(window.pop_front());
        window.push_back(int'(d));
      end
      idle = 0;
      s = 0;
      foreach (window[i]) s += window[i];
      due_q.push_back(edge_n + 1);
      val_q.push_back(s / TB_DEPTH);
    end else begin
      idle++;
      if (m_track && idle >= TB_TIMEOUT) begin
        m_track      = 1'b0;
        exp_stale    = 1'b1;
        exp_obstacle = 1'b1;
      end
    end
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({filtered_mm, filt_valid, reject, obstacle, stale} !== {16'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_values: got mm=%0d fv=%b rej=%b obs=%b stale=%b, want mm=0 fv=0 rej=0 obs=1 stale=1",
               filtered_mm, filt_valid, reject, obstacle, stale);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'($urandom));
      checks++;
      if ({filt_valid, filtered_mm, obstacle, stale, reject} !== {exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject}) begin
        errors++;
        $display("[TB] FAIL reset_idle: got fv=%b mm=%0d obs=%b stale=%b rej=%b, want fv=%b mm=%0d obs=%b stale=%b rej=%b",
                 filt_valid, filtered_mm, obstacle, stale, reject, exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject);
      end
    end
  endtask

  task automatic test_first_sample();
    tick(1'b1, 16'd1000);
    checks++;
    if ({stale, obstacle, filt_valid} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL first_prefill: got stale=%b obs=%b fv=%b, want stale=0 obs=1 fv=0", stale, obstacle, filt_valid);
    end
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, obstacle, stale} !== {1'b1, 16'd1000, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL first_output: got fv=%b mm=%0d obs=%b stale=%b, want fv=1 mm=1000 obs=0 stale=0",
               filt_valid, filtered_mm, obstacle, stale);
    end
    tick(1'b0, 16'd0);
    checks++;
    if (filt_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_pulse_width: got fv=%b want fv=0", filt_valid);
    end
  endtask

  task automatic test_average();
    int samples[5] = '{1000, 1000, 1000, 200, 200};
    int expect_mm[5] = '{1000, 1000, 1000, 800, 600};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'(samples[i]));
      tick(1'b0, 16'd0);
      checks++;
      if ({filt_valid, filtered_mm} !== {1'b1, 16'(expect_mm[i])} ||
          {obstacle, stale} !== {exp_obstacle, exp_stale}) begin
        errors++;
        $display("[TB] FAIL average_%0d: got fv=%b mm=%0d obs=%b stale=%b, want fv=1 mm=%0d obs=%b stale=%b",
                 i, filt_valid, filtered_mm, obstacle, stale, expect_mm[i], exp_obstacle, exp_stale);
      end
    end
  endtask

  task automatic test_reject();
    logic [15:0] held;
    int bad[3] = '{0, 5000, 4001};
    held = exp_filtered;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'(bad[i]));
      checks++;
      if ({reject, filt_valid} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL reject_pulse_%0d: got rej=%b fv=%b, want rej=1 fv=0", bad[i], reject, filt_valid);
      end
      tick(1'b0, 16'd0);
      checks++;
      if ({reject, filt_valid, filtered_mm} !== {1'b0, 1'b0, held}) begin
        errors++;
        $display("[TB] FAIL reject_hold_%0d: got rej=%b fv=%b mm=%0d, want rej=0 fv=0 mm=%0d",
                 bad[i], reject, filt_valid, filtered_mm, held);
      end
    end
    // 4000 is the largest accepted distance
    tick(1'b1, 16'd4000);
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, reject} !== {1'b1, exp_filtered, 1'b0} || exp_fv !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_max: got fv=%b mm=%0d rej=%b, want fv=1 mm=%0d rej=0",
               filt_valid, filtered_mm, reject, exp_filtered);
    end
    // rejected samples in the idle run must not restart the timeout
    for (int k = 2; k <= TB_TIMEOUT; k++) begin
      tick(k[0] == 1'b0, 16'd0);
      checks++;
      if (stale !== (k == TB_TIMEOUT) || obstacle !== exp_obstacle || reject !== exp_reject) begin
        errors++;
        $display("[TB] FAIL reject_timeout_%0d: got stale=%b obs=%b rej=%b, want stale=%b obs=%b rej=%b",
                 k, stale, obstacle, reject, (k == TB_TIMEOUT), exp_obstacle, exp_reject);
      end
    end
  endtask

  task automatic test_timeout_recovery();
    tick(1'b1, 16'd800);
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, stale, obstacle} !== {1'b1, 16'd800, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL recover_800: got fv=%b mm=%0d stale=%b obs=%b, want fv=1 mm=800 stale=0 obs=0",
               filt_valid, filtered_mm, stale, obstacle);
    end
    for (int k = 2; k <= TB_TIMEOUT; k++) begin
      tick(1'b0, 16'd0);
      checks++;
      if ({stale, obstacle} !== {2{k == TB_TIMEOUT}} || filt_valid !== 1'b0 || filtered_mm !== 16'd800) begin
        errors++;
        $display("[TB] FAIL timeout_%0d: got stale=%b obs=%b fv=%b mm=%0d, want stale=%b obs=%b fv=0 mm=800",
                 k, stale, obstacle, filt_valid, filtered_mm, (k == TB_TIMEOUT), (k == TB_TIMEOUT));
      end
    end
    tick(1'b1, 16'd800);
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, stale, obstacle} !== {1'b1, 16'd800, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL recover_again: got fv=%b mm=%0d stale=%b obs=%b, want fv=1 mm=800 stale=0 obs=0",
               filt_valid, filtered_mm, stale, obstacle);
    end
    for (int k = 2; k < TB_TIMEOUT; k++) tick(1'b0, 16'd0);
    // sample lands in the expiry cycle and must win
    tick(1'b1, 16'd900);
    checks++;
    if (stale !== 1'b0 || obstacle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL expiry_race: got stale=%b obs=%b, want stale=0 obs=0", stale, obstacle);
    end
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, stale} !== {1'b1, 16'd825, 1'b0}) begin
      errors++;
      $display("[TB] FAIL expiry_avg: got fv=%b mm=%0d stale=%b, want fv=1 mm=825 stale=0", filt_valid, filtered_mm, stale);
    end
  endtask

  task automatic test_hysteresis();
    int level[6] = '{500, 350, 299, 350, 400, 401};
    logic want_obs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < TB_DEPTH; r++) begin
        tick(1'b1, 16'(level[i]));
        tick(1'b0, 16'd0);
        checks++;
        if ({filt_valid, filtered_mm, obstacle, stale} !== {exp_fv, exp_filtered, exp_obstacle, exp_stale}) begin
          errors++;
          $display("[TB] FAIL hyst_step_%0d_%0d: got fv=%b mm=%0d obs=%b stale=%b, want fv=%b mm=%0d obs=%b stale=%b",
                   level[i], r, filt_valid, filtered_mm, obstacle, stale, exp_fv, exp_filtered, exp_obstacle, exp_stale);
        end
      end
      checks++;
      if ({filtered_mm, obstacle} !== {16'(level[i]), want_obs[i]}) begin
        errors++;
        $display("[TB] FAIL hyst_level_%0d: got mm=%0d obs=%b, want mm=%0d obs=%b",
                 level[i], filtered_mm, obstacle, level[i], want_obs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    int pulses;
    sent   = 0;
    pulses = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 24) begin
        tick(1'b1, 16'($urandom_range(1, TB_MAX)));
        sent++;
      end else begin
        tick(1'b0, 16'd0);
      end
      if (filt_valid === 1'b1) pulses++;
      checks++;
      if ({filt_valid, filtered_mm, obstacle, stale, reject} !== {exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject}) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got fv=%b mm=%0d obs=%b stale=%b rej=%b, want fv=%b mm=%0d obs=%b stale=%b rej=%b",
                 i, filt_valid, filtered_mm, obstacle, stale, reject, exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject);
      end
    end
    checks++;
    if (pulses !== sent) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d filt_valid pulses, want %0d", pulses, sent);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3) != 0, rand_dist());
      checks++;
      if ({filt_valid, filtered_mm, obstacle, stale, reject} !== {exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject}) begin
        errors++;
        $display("[TB] FAIL random_%0d: got fv=%b mm=%0d obs=%b stale=%b rej=%b, want fv=%b mm=%0d obs=%b stale=%b rej=%b",
                 i, filt_valid, filtered_mm, obstacle, stale, reject, exp_fv, exp_filtered, exp_obstacle, exp_stale, exp_reject);
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 16'd1500);
    tick(1'b1, 16'd2500);
    apply_reset();
    checks++;
    if ({filtered_mm, filt_valid, reject, obstacle, stale} !== {16'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midreset_values: got mm=%0d fv=%b rej=%b obs=%b stale=%b, want mm=0 fv=0 rej=0 obs=1 stale=1",
               filtered_mm, filt_valid, reject, obstacle, stale);
    end
    tick(1'b0, 16'd0);
    checks++;
    if ({filtered_mm, filt_valid, obstacle, stale} !== {16'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midreset_flush: got mm=%0d fv=%b obs=%b stale=%b, want mm=0 fv=0 obs=1 stale=1",
               filtered_mm, filt_valid, obstacle, stale);
    end
    tick(1'b1, 16'd700);
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm, obstacle, stale} !== {1'b1, 16'd700, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_700: got fv=%b mm=%0d obs=%b stale=%b, want fv=1 mm=700 obs=0 stale=0",
               filt_valid, filtered_mm, obstacle, stale);
    end
    tick(1'b1, 16'd300);
    tick(1'b0, 16'd0);
    checks++;
    if ({filt_valid, filtered_mm} !== {1'b1, 16'd600}) begin
      errors++;
      $display("[TB] FAIL midreset_residue: got fv=%b mm=%0d, want fv=1 mm=600", filt_valid, filtered_mm);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    edge_n       = 0;
    reset        = 1'b0;
    sample_valid = 1'b0;
    distance     = 16'd0;
    model_reset();
    #1;
    $display("[TB] starting distance_filter bench");
    test_reset();
    test_first_sample();
    test_average();
    test_reject();
    test_timeout_recovery();
    test_hysteresis();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
Downstream consumer of the ultrasonic ranging stage; takes each raw distance measurement (mm) with its valid strobe. Rejects out-of-range samples, smooths accepted ones with a power-of-two moving average, and derives a hysteretic obstacle flag. A watchdog flags stale data when the sensor stops reporting. Feeds the vehicle steering/motor control logic.

Parameters:
WIDTH, 16, distance width in mm (matches the ranging stage output)
AVG_LOG2, 2, log2 of moving-average depth (default 4 samples)
MAX_MM, 4000, largest accepted raw distance; larger values are rejected
NEAR_MM, 300, obstacle asserts when filtered distance < NEAR_MM
FAR_MM, 400, obstacle deasserts when filtered distance > FAR_MM; must be > NEAR_MM
TIMEOUT, 100000, clk cycles without an accepted sample before stale is raised

Ports:
clk  input  1  block clock; sample_valid is synchronous to it
reset  input  1  synchronous, active-low reset; sampled on the clk rising edge
distance  input  WIDTH  raw measurement in mm, qualified by sample_valid
sample_valid  input  1  one-cycle pulse per new measurement; the upstream stage synchronizes it to clk
filtered_mm  output  WIDTH  moving-average distance in mm
filt_valid  output  1  one-cycle pulse when filtered_mm updates
obstacle  output  1  hysteretic near-object flag; fail-safe high
stale  output  1  no accepted sample within TIMEOUT cycles
reject  output  1  one-cycle pulse when a sample is discarded

Behaviour:
- Reset (reset==0 at a clk edge): filtered_mm=0, filt_valid=0, reject=0, obstacle=1, stale=1, sum=0, buffer cleared, timeout counter=0, state=EMPTY. Reset mid-operation discards everything on that edge.
- Acceptance: sample_valid && distance!=0 && distance<=MAX_MM. A sample is rejected if sample_valid && (distance==0 || distance>MAX_MM).
- A rejected sample pulses reject in cycle c+1. There is no filt_valid, buffer and sum are unchanged, and the timeout counter is not cleared.
- FSM states:
  - EMPTY: after reset.
  - TRACK: normal operation.
  - STALE: timed out.
  - EMPTY/STALE + accepted sample: prefill all 2^AVG_LOG2 entries with the sample, set sum = sample<<AVG_LOG2, clear stale, go to TRACK.
  - TRACK + accepted sample: sum <= sum - oldest + sample, overwrite oldest entry, advance write pointer (wraps modulo 2^AVG_LOG2).
  - TRACK + timeout counter reaching TIMEOUT-1 with no accepted sample that cycle: go to STALE with stale=1 and obstacle=1. filtered_mm holds its last value and filt_valid is not pulsed.
- Timing: sample_valid in cycle c updates sum/buffer at the end of c. filtered_mm = sum>>AVG_LOG2 is registered at the end of c+1, and filt_valid is high in cycle c+2 only (latency 2).
- Width: sum is WIDTH+AVG_LOG2 bits and cannot overflow. The division is truncating.
- Hysteresis is evaluated on the new filtered value in the same register stage as filtered_mm:
  - value < NEAR_MM: obstacle=1.
  - value > FAR_MM: obstacle=0.
  - otherwise: hold.
  - A value exactly equal to NEAR_MM or FAR_MM holds.
- Timeout counter: counts every cycle and saturates at TIMEOUT-1. It is cleared by every accepted sample.
- Simultaneous accepted sample and timeout expiry: the sample wins. The counter clears and the state stays TRACK.
- Back-to-back sample_valid pulses on consecutive cycles must all be accepted; the pipeline has no stall.

Decomposition:
- Shared package distance_pkg holds:
  - WIDTH
  - the state encoding (EMPTY, TRACK, STALE)
  - default MAX_MM/NEAR_MM/FAR_MM/TIMEOUT constants, shared with the ranging stage and motor control
- Sub-module moving_avg_buf holds the circular buffer, write pointer, running sum and prefill. Its interface is load (prefill), push, din, and sum.
- The FSM, hysteresis, reject logic and timeout stay in distance_filter.

Test Plan:
- Reset, then one sample 1000 -> filt_valid 2 cycles later with filtered_mm=1000, stale 1->0, obstacle 1->0 (1000 > FAR_MM).
- Samples 1000,1000,1000,200 in TRACK -> filtered_mm 1000,1000,1000,800. A fifth sample 200 -> 600.
- Hysteresis sweep with filtered values 500,350,299,350,400,401 -> obstacle 0,0,1,1,1,0.
- Samples 0 and 5000 -> reject pulses, no filt_valid, filtered_mm unchanged, timeout counter not cleared.
- Timeout and recovery:
  - With TIMEOUT=16, no samples for 16 cycles -> stale=1, obstacle=1.
  - Next sample 800 -> prefill, filtered_mm=800, stale=0, obstacle=0.
  - An accepted sample in the exact expiry cycle -> stale stays 0.
- reset driven low mid-stream, for one edge -> all outputs at reset values the next cycle. The following sample 700 is prefilled (filtered_mm=700), with no residue from old buffer contents.
